// File: rtl/axis_srl_buffer_pkg.sv
// Shared helpers for the SRL-based AXI-Stream buffer family: constant log2 and
// the packed-field width rule used to build {data, keep, last, id, dest, user}.
package axis_srl_buffer_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A disabled sideband field occupies no bits in the stored word.
  function automatic int field_width(input int enable, input int width);
    return (enable != 0) ? width : 0;
  endfunction

  // Packed-word offsets, user at the LSB end and data at the MSB end.
  function automatic int dest_offset(input int user_w);
    return user_w;
  endfunction

  function automatic int id_offset(input int user_w, input int dest_w);
    return user_w + dest_w;
  endfunction

  function automatic int last_offset(input int user_w, input int dest_w, input int id_w);
    return user_w + dest_w + id_w;
  endfunction

  function automatic int keep_offset(input int user_w, input int dest_w, input int id_w,
                                     input int last_w);
    return user_w + dest_w + id_w + last_w;
  endfunction

endpackage

// File: rtl/axis_srl_buffer_mem.sv
// DEPTH x WIDTH shift array with combinational read port; no reset so it can
// map onto SRL primitives.
module axis_srl_buffer_mem
  import axis_srl_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Shift every entry up by one and load the new word into entry 0.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_srl_buffer.sv
// AXI-Stream elastic buffer over an SRL shift array with pointer read, with
// occupancy/almost-full status and an optional store-and-forward frame mode.
module axis_srl_buffer
  import axis_srl_buffer_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int KEEP_ENABLE        = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int LAST_ENABLE        = 1,
  parameter int ID_ENABLE          = 0,
  parameter int ID_WIDTH           = 8,
  parameter int DEST_ENABLE        = 0,
  parameter int DEST_WIDTH         = 8,
  parameter int USER_ENABLE        = 1,
  parameter int USER_WIDTH         = 1,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_THRESH = DEPTH - 4,
  parameter int FRAME_MODE         = 0,
  localparam int CW                = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [CW-1:0]         status_count,
  output logic                  status_almost_full,
  output logic [CW-1:0]         status_frame_count,
  output logic                  status_overflow
);

  localparam int USER_W   = field_width(USER_ENABLE, USER_WIDTH);
  localparam int DEST_W   = field_width(DEST_ENABLE, DEST_WIDTH);
  localparam int ID_W     = field_width(ID_ENABLE, ID_WIDTH);
  localparam int LAST_W   = field_width(LAST_ENABLE, 1);
  localparam int KEEP_W   = field_width(KEEP_ENABLE, KEEP_WIDTH);
  localparam int USER_OFF = 0;
  localparam int DEST_OFF = dest_offset(USER_W);
  localparam int ID_OFF   = id_offset(USER_W, DEST_W);
  localparam int LAST_OFF = last_offset(USER_W, DEST_W, ID_W);
  localparam int KEEP_OFF = keep_offset(USER_W, DEST_W, ID_W, LAST_W);
  localparam int DATA_OFF = KEEP_OFF + KEEP_W;
  localparam int WORD_W   = DATA_OFF + DATA_WIDTH;
  localparam int AW       = clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};

  logic [CW-1:0]     count_q, count_d, frame_count_q, frame_count_d, count_m1_s;
  logic              release_q, release_d, ready_en_q, full_q, almost_full_q, overflow_q;
  logic              wr_s, rd_s, trig_s, s_last_s, m_last_s;
  logic [WORD_W-1:0] wr_word_s, rd_word_s;

  assign wr_word_s[DATA_OFF +: DATA_WIDTH] = s_axis_tdata;
  assign m_axis_tdata = rd_word_s[DATA_OFF +: DATA_WIDTH];

  if (KEEP_ENABLE != 0) begin : g_keep
    assign wr_word_s[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
    assign m_axis_tkeep = rd_word_s[KEEP_OFF +: KEEP_WIDTH];
  end else begin : g_no_keep
    logic unused_keep_s;
    assign unused_keep_s = ^s_axis_tkeep;
    assign m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
  end

  // Without a stored tlast every word is treated as a frame end on the output.
  if (LAST_ENABLE != 0) begin : g_last
    assign wr_word_s[LAST_OFF] = s_axis_tlast;
    assign s_last_s = s_axis_tlast;
    assign m_last_s = rd_word_s[LAST_OFF];
  end else begin : g_no_last
    logic unused_last_s;
    assign unused_last_s = s_axis_tlast;
    assign s_last_s = 1'b0;
    assign m_last_s = 1'b1;
  end
  assign m_axis_tlast = m_last_s;

  if (ID_ENABLE != 0) begin : g_id
    assign wr_word_s[ID_OFF +: ID_WIDTH] = s_axis_tid;
    assign m_axis_tid = rd_word_s[ID_OFF +: ID_WIDTH];
  end else begin : g_no_id
    logic unused_id_s;
    assign unused_id_s = ^s_axis_tid;
    assign m_axis_tid  = {ID_WIDTH{1'b0}};
  end

  if (DEST_ENABLE != 0) begin : g_dest
    assign wr_word_s[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
    assign m_axis_tdest = rd_word_s[DEST_OFF +: DEST_WIDTH];
  end else begin : g_no_dest
    logic unused_dest_s;
    assign unused_dest_s = ^s_axis_tdest;
    assign m_axis_tdest  = {DEST_WIDTH{1'b0}};
  end

  if (USER_ENABLE != 0) begin : g_user
    assign wr_word_s[USER_OFF +: USER_WIDTH] = s_axis_tuser;
    assign m_axis_tuser = rd_word_s[USER_OFF +: USER_WIDTH];
  end else begin : g_no_user
    logic unused_user_s;
    assign unused_user_s = ^s_axis_tuser;
    assign m_axis_tuser  = {USER_WIDTH{1'b0}};
  end

  assign s_axis_tready = ready_en_q & ~full_q;
  assign m_axis_tvalid = (count_q != ZERO_C) &
                         ((FRAME_MODE == 0) | (frame_count_q != ZERO_C) | release_q);
  assign wr_s       = s_axis_tvalid & s_axis_tready;
  assign rd_s       = m_axis_tvalid & m_axis_tready;
  assign count_m1_s = count_q - ONE_C;

  axis_srl_buffer_mem #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_mem (
    .clk        (clk),
    .shift_en_i (wr_s),
    .data_i     (wr_word_s),
    .rd_addr_i  (count_m1_s[AW-1:0]),
    .data_o     (rd_word_s)
  );

  // Next occupancy, complete-frame tally and forced-release flag.
  always_comb begin
    count_d       = count_q;
    frame_count_d = frame_count_q;
    release_d     = release_q;
    trig_s        = 1'b0;
    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (FRAME_MODE != 0) begin
      case ({wr_s & s_last_s, rd_s & m_last_s})
        2'b10:   frame_count_d = frame_count_q + ONE_C;
        2'b01:   frame_count_d = frame_count_q - ONE_C;
        default: frame_count_d = frame_count_q;
      endcase
      // A full buffer holding no complete frame can never drain on its own.
      trig_s = (count_q == DEPTH_C) & (frame_count_q == ZERO_C) & ~release_q;
      if (trig_s) begin
        release_d = 1'b1;
      end else if ((rd_s & m_last_s) | (count_d == ZERO_C)) begin
        release_d = 1'b0;
      end else begin
        release_d = release_q;
      end
    end else begin
      frame_count_d = ZERO_C;
      release_d     = 1'b0;
    end
  end

  // Control and status registers; stored words are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= ZERO_C;
      frame_count_q <= ZERO_C;
      release_q     <= 1'b0;
      ready_en_q    <= 1'b0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
      release_q     <= release_d;
      ready_en_q    <= 1'b1;
      full_q        <= (count_d == DEPTH_C);
      almost_full_q <= (count_d >= THRESH_C);
      overflow_q    <= trig_s;
    end
  end

  assign status_count       = count_q;
  assign status_almost_full = almost_full_q;
  assign status_frame_count = frame_count_q;
  assign status_overflow    = overflow_q;

endmodule

// File: tb/tb_axis_srl_buffer.sv
// Bench for axis_srl_buffer: a word-FIFO instance and a frame-mode instance,
// both checked every cycle against queue-based reference models.
module tb_axis_srl_buffer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic        user;
  } word_t;

  typedef struct {
    bit          vin;
    logic [31:0] data;
    bit          rdy;
    bit          e_tready;
    bit          e_tvalid;
    int          e_count;
    bit          e_af;
    logic [31:0] e_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit rdyen = 1'b0;
  bit rel1 = 1'b0;
  bit ovf1 = 1'b0;
  int ovf_seen = 0;
  int seen_out1 = 0;
  word_t q0[$];
  word_t q1[$];

  logic [31:0] s0_data, m0_data;
  logic [3:0]  s0_keep, m0_keep, s0_id, m0_id;
  logic [7:0]  s0_dest, m0_dest_unused;
  logic        s0_valid, s0_ready, s0_last, s0_user;
  logic        m0_valid, m0_ready, m0_last, m0_user;
  logic [4:0]  st0_count, st0_fc;
  logic        st0_af, st0_ovf;

  logic [15:0] s1_data, m1_data;
  logic [1:0]  s1_keep, m1_keep;
  logic [7:0]  s1_id, s1_dest, m1_id_unused, m1_dest_unused;
  logic        s1_valid, s1_ready, s1_last, s1_user;
  logic        m1_valid, m1_ready, m1_last, m1_user;
  logic [4:0]  st1_count, st1_fc;
  logic        st1_af, st1_ovf;

  axis_srl_buffer #(.DATA_WIDTH(32), .ID_ENABLE(1), .ID_WIDTH(4), .DEPTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s0_data), .s_axis_tkeep(s0_keep), .s_axis_tvalid(s0_valid),
    .s_axis_tready(s0_ready), .s_axis_tlast(s0_last), .s_axis_tid(s0_id),
    .s_axis_tdest(s0_dest), .s_axis_tuser(s0_user),
    .m_axis_tdata(m0_data), .m_axis_tkeep(m0_keep), .m_axis_tvalid(m0_valid),
    .m_axis_tready(m0_ready), .m_axis_tlast(m0_last), .m_axis_tid(m0_id),
    .m_axis_tdest(m0_dest_unused), .m_axis_tuser(m0_user),
    .status_count(st0_count), .status_almost_full(st0_af),
    .status_frame_count(st0_fc), .status_overflow(st0_ovf)
  );

  axis_srl_buffer #(.DATA_WIDTH(16), .DEPTH(16), .FRAME_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s1_data), .s_axis_tkeep(s1_keep), .s_axis_tvalid(s1_valid),
    .s_axis_tready(s1_ready), .s_axis_tlast(s1_last), .s_axis_tid(s1_id),
    .s_axis_tdest(s1_dest), .s_axis_tuser(s1_user),
    .m_axis_tdata(m1_data), .m_axis_tkeep(m1_keep), .m_axis_tvalid(m1_valid),
    .m_axis_tready(m1_ready), .m_axis_tlast(m1_last), .m_axis_tid(m1_id_unused),
    .m_axis_tdest(m1_dest_unused), .m_axis_tuser(m1_user),
    .status_count(st1_count), .status_almost_full(st1_af),
    .status_frame_count(st1_fc), .status_overflow(st1_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t rnd_word();
    word_t w;
    w.data = $urandom;
    w.keep = 4'($urandom);
    w.last = 1'($urandom);
    w.id   = 4'($urandom);
    w.user = 1'($urandom);
    return w;
  endfunction

  // One cycle of the word FIFO: check at negedge, drive, advance the model.
  task automatic cyc0(input bit vin, input word_t w, input bit rdy);
    bit et, ev;
    int n;
    n  = q0.size();
    et = rdyen && (n != 16);
    ev = (n != 0);
    chk("s0_tready", s0_ready, et);
    chk("m0_tvalid", m0_valid, ev);
    chk("s0_count", st0_count, n);
    chk("s0_almost_full", st0_af, n >= 12);
    chk("s0_frame_count", st0_fc, 0);
    chk("s0_overflow", st0_ovf, 0);
    if (ev) begin
      chk("m0_tdata", m0_data, q0[0].data);
      chk("m0_tkeep", m0_keep, q0[0].keep);
      chk("m0_tlast", m0_last, q0[0].last);
      chk("m0_tid", m0_id, q0[0].id);
      chk("m0_tuser", m0_user, q0[0].user);
    end
    s0_valid = vin; s0_data = w.data; s0_keep = w.keep;
    s0_last = w.last; s0_id = w.id; s0_user = w.user; m0_ready = rdy;
    if (rdy && ev) void'(q0.pop_front());
    if (vin && et) q0.push_back(w);
    @(negedge clk);
    if (rst_n) rdyen = 1'b1;
  endtask

  // One cycle of the frame-mode instance with release/overflow tracking.
  task automatic cyc1(input bit vin, input word_t w, input bit rdy);
    bit et, ev, trig, lastrd;
    int n, fr;
    n  = q1.size();
    fr = 0;
    foreach (q1[i]) if (q1[i].last) fr++;
    et = rdyen && (n != 16);
    ev = (n != 0) && ((fr != 0) || rel1);
    chk("s1_tready", s1_ready, et);
    chk("m1_tvalid", m1_valid, ev);
    chk("s1_count", st1_count, n);
    chk("s1_frame_count", st1_fc, fr);
    chk("s1_almost_full", st1_af, n >= 12);
    chk("s1_overflow", st1_ovf, ovf1);
    if (st1_ovf) ovf_seen++;
    if (ev) begin
      chk("m1_tdata", m1_data, q1[0].data[15:0]);
      chk("m1_tkeep", m1_keep, q1[0].keep[1:0]);
      chk("m1_tlast", m1_last, q1[0].last);
      chk("m1_tuser", m1_user, q1[0].user);
    end
    s1_valid = vin; s1_data = w.data[15:0]; s1_keep = w.keep[1:0];
    s1_last = w.last; s1_user = w.user; m1_ready = rdy;
    if (m1_valid && rdy) seen_out1++;
    trig   = (n == 16) && (fr == 0) && !rel1;
    lastrd = rdy && ev && q1[0].last;
    if (rdy && ev) void'(q1.pop_front());
    if (vin && et) q1.push_back(w);
    ovf1 = trig;
    if (trig) rel1 = 1'b1;
    else if (lastrd || (q1.size() == 0)) rel1 = 1'b0;
    @(negedge clk);
    if (rst_n) rdyen = 1'b1;
  endtask

  initial begin
    vec_t  tbl[36];
    word_t w;
    int    wrote, n;
    bit    vin, rdy;

    for (int i = 0; i < 18; i++) begin
      tbl[i] = '{1'b1, 32'(i), 1'b0, (i < 16), (i > 0), ((i < 16) ? i : 16), (i >= 12), 32'h0};
    end
    for (int j = 0; j < 18; j++) begin
      n = (j <= 16) ? (16 - j) : 0;
      tbl[18 + j] = '{1'b0, 32'h0, 1'b1, (n != 16), (n > 0), n, (n >= 12), 32'(j)};
    end

    rst_n = 1'b0;
    {s0_valid, s0_data, s0_keep, s0_last, s0_id, s0_dest, s0_user, m0_ready} = '0;
    {s1_valid, s1_data, s1_keep, s1_last, s1_id, s1_dest, s1_user, m1_ready} = '0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_s0_tready", s0_ready, 0);
      chk("rst_m0_tvalid", m0_valid, 0);
      chk("rst_s0_count", st0_count, 0);
      chk("rst_s1_tready", s1_ready, 0);
      chk("rst_m1_tvalid", m1_valid, 0);
    end
    rst_n = 1'b1;
    w = rnd_word();
    cyc0(1'b0, w, 1'b0);
    cyc0(1'b0, w, 1'b0);

    // Fill with m_tready low, then drain in order.
    for (int k = 0; k < 36; k++) begin
      chk("tbl_tready", s0_ready, tbl[k].e_tready);
      chk("tbl_tvalid", m0_valid, tbl[k].e_tvalid);
      chk("tbl_count", st0_count, tbl[k].e_count);
      chk("tbl_almost_full", st0_af, tbl[k].e_af);
      if (tbl[k].e_tvalid) chk("tbl_tdata", m0_data, tbl[k].e_data);
      w = rnd_word();
      w.data = tbl[k].data;
      cyc0(tbl[k].vin, w, tbl[k].rdy);
    end

    for (int k = 0; k < 100; k++) begin
      cyc0(1'b1, rnd_word(), 1'b1);
      chk("stream_count_le1", st0_count <= 5'd1, 1);
    end
    cyc0(1'b0, w, 1'b1);

    wrote = 0;
    for (int c = 0; (c < 20000) && (wrote < 1000); c++) begin
      vin = 1'($urandom);
      rdy = 1'($urandom);
      if (vin && rdyen && (q0.size() != 16)) wrote++;
      cyc0(vin, rnd_word(), rdy);
    end
    chk("bp_words_written", wrote, 1000);
    for (int c = 0; (c < 40) && (q0.size() != 0); c++) cyc0(1'b0, w, 1'b1);
    cyc0(1'b0, w, 1'b1);
    chk("bp_drained_count", st0_count, 0);

    // Frame mode: 5-word frame held until its tlast is stored.
    cyc1(1'b0, w, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      w = rnd_word();
      w.last = (i == 5);
      cyc1(1'b1, w, 1'b1);
    end
    for (int i = 0; i < 8; i++) cyc1(1'b0, w, 1'b1);
    chk("frame5_words_out", seen_out1, 5);
    chk("frame5_overflow_pulses", ovf_seen, 0);

    // Frame mode: 20-word frame forces a release once the buffer fills.
    n = 0;
    for (int c = 0; (c < 200) && (n < 20); c++) begin
      w = rnd_word();
      w.data = 32'(n);
      w.last = (n == 19);
      vin = (rdyen && (q1.size() != 16));
      cyc1(1'b1, w, 1'b1);
      if (vin) n++;
    end
    chk("frame20_words_in", n, 20);
    for (int i = 0; i < 30; i++) cyc1(1'b0, w, 1'b1);
    chk("frame20_words_out", seen_out1, 25);
    chk("frame20_overflow_pulses", ovf_seen, 1);
    chk("frame20_frame_count", st1_fc, 0);

    // Asynchronous reset with words stored.
    for (int i = 0; i < 3; i++) cyc0(1'b1, rnd_word(), 1'b0);
    chk("pre_reset_tvalid", m0_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m0_tvalid", m0_valid, 0);
    chk("midrst_s0_count", st0_count, 0);
    chk("midrst_s0_tready", s0_ready, 0);
    q0.delete();
    rdyen = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
